// File: rtl/gpio_iomem.sv
`default_nettype none
// ============================================================================
// Module   : gpio_iomem
// Brief    : Memory-mapped GPIO with synchronised, optionally debounced inputs,
//            sticky rising-edge flags and a level interrupt.
//            Define GPIO_IOMEM_DEBOUNCE_EN to build the per-pin debouncers.
// Revision : 1.0 - initial release
// ============================================================================
module gpio_iomem #(
    parameter int N_IN       = 5,
    parameter int N_OUT      = 16,
    parameter int DEB_CYCLES = 65000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             iomem_valid,
    output logic             iomem_ready,
    input  logic [3:0]       iomem_wstrb,
    input  logic [31:0]      iomem_addr,
    input  logic [31:0]      iomem_wdata,
    output logic [31:0]      iomem_rdata,
    input  logic [N_IN-1:0]  pins_in,
    output logic [N_OUT-1:0] pins_out,
    output logic             irq
);

    localparam logic [1:0] c_REG_OUT    = 2'd0;
    localparam logic [1:0] c_REG_IN     = 2'd1;
    localparam logic [1:0] c_REG_EDGE   = 2'd2;
    localparam logic [1:0] c_REG_IRQ_EN = 2'd3;

    logic              r_ready;
    logic [31:0]       r_rdata;
    logic [N_OUT-1:0]  r_out;
    logic [N_IN-1:0]   r_sync1;
    logic [N_IN-1:0]   r_in;
    logic [N_IN-1:0]   r_edge;
    logic [N_IN-1:0]   r_irq_en;
    logic              r_irq;

    logic              w_acc;
    logic              w_wr;
    logic [1:0]        w_sel;
    logic [31:0]       w_wmask;
    logic [31:0]       w_wdm;
    logic [31:0]       w_rd_val;
    logic [N_IN-1:0]   w_in_nxt;
    logic [N_IN-1:0]   w_rise;
    logic [N_IN-1:0]   w_edge_clr;
    logic              w_unused_bits;

    assign w_acc   = iomem_valid & ~r_ready;
    assign w_wr    = w_acc & (|iomem_wstrb);
    assign w_sel   = iomem_addr[3:2];
    assign w_wmask = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}},
                      {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
    assign w_wdm   = iomem_wdata & w_wmask;
    assign w_unused_bits = ^{iomem_addr[31:4], iomem_addr[1:0], w_wdm};

    always_ff @(posedge clk) begin
        if (reset) r_sync1 <= '0;
        else       r_sync1 <= pins_in;
    end

`ifdef GPIO_IOMEM_DEBOUNCE_EN
    localparam int              c_CW   = $clog2(DEB_CYCLES);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(DEB_CYCLES - 1);

    logic [N_IN-1:0] r_sync2;

    always_ff @(posedge clk) begin
        if (reset) r_sync2 <= '0;
        else       r_sync2 <= r_sync1;
    end

    // IN follows the synchronised pin only after DEB_CYCLES consecutive disagreeing cycles
    for (genvar gi = 0; gi < N_IN; gi++) begin : g_deb
        logic [c_CW-1:0] r_cnt;
        logic            w_diff;
        logic            w_take;

        assign w_diff         = r_sync2[gi] ^ r_in[gi];
        assign w_take         = w_diff && (r_cnt == c_LAST);
        assign w_in_nxt[gi]   = w_take ? r_sync2[gi] : r_in[gi];

        always_ff @(posedge clk) begin
            if (reset || !w_diff || w_take) r_cnt <= '0;
            else                            r_cnt <= r_cnt + c_CW'(1);
        end
    end
`else
    localparam int c_unused_deb_cycles = DEB_CYCLES;

    // r_in acts as the second synchroniser stage
    assign w_in_nxt = r_sync1;
`endif

    assign w_rise     = w_in_nxt & ~r_in;
    assign w_edge_clr = (w_wr && (w_sel == c_REG_EDGE)) ? w_wdm[N_IN-1:0] : '0;

    always_comb begin
        w_rd_val = '0;
        case (w_sel)
            c_REG_OUT:    w_rd_val[N_OUT-1:0] = r_out;
            c_REG_IN:     w_rd_val[N_IN-1:0]  = r_in;
            c_REG_EDGE:   w_rd_val[N_IN-1:0]  = r_edge;
            c_REG_IRQ_EN: w_rd_val[N_IN-1:0]  = r_irq_en;
            default:      w_rd_val            = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ready  <= 1'b0;
            r_rdata  <= '0;
            r_out    <= '0;
            r_in     <= '0;
            r_edge   <= '0;
            r_irq_en <= '0;
            r_irq    <= 1'b0;
        end else begin
            r_ready <= w_acc;
            r_rdata <= w_acc ? w_rd_val : '0;
            r_in    <= w_in_nxt;
            // a new rising edge overrides a simultaneous clear
            r_edge  <= (r_edge & ~w_edge_clr) | w_rise;
            r_irq   <= |(r_edge & r_irq_en);
            if (w_wr && (w_sel == c_REG_OUT))
                r_out <= (r_out & ~w_wmask[N_OUT-1:0]) | w_wdm[N_OUT-1:0];
            if (w_wr && (w_sel == c_REG_IRQ_EN))
                r_irq_en <= (r_irq_en & ~w_wmask[N_IN-1:0]) | w_wdm[N_IN-1:0];
        end
    end

    assign iomem_ready = r_ready;
    assign iomem_rdata = r_rdata;
    assign pins_out    = r_out;
    assign irq         = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_gpio_iomem.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpio_iomem
// Brief    : Scoreboard bench for gpio_iomem (N_IN=5, N_OUT=16, DEB_CYCLES=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpio_iomem;

    localparam int N_IN       = 5;
    localparam int N_OUT      = 16;
    localparam int DEB_CYCLES = 4;
`ifdef GPIO_IOMEM_DEBOUNCE_EN
    localparam int c_LAT = 2 + DEB_CYCLES;
    localparam bit c_DEB = 1'b1;
`else
    localparam int c_LAT = 2;
    localparam bit c_DEB = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             iomem_valid;
    logic             iomem_ready;
    logic [3:0]       iomem_wstrb;
    logic [31:0]      iomem_addr;
    logic [31:0]      iomem_wdata;
    logic [31:0]      iomem_rdata;
    logic [N_IN-1:0]  pins_in;
    logic [N_OUT-1:0] pins_out;
    logic             irq;

    always #5 clk = ~clk;

    gpio_iomem #(
        .N_IN       (N_IN),
        .N_OUT      (N_OUT),
        .DEB_CYCLES (DEB_CYCLES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .iomem_valid (iomem_valid),
        .iomem_ready (iomem_ready),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata),
        .pins_in     (pins_in),
        .pins_out    (pins_out),
        .irq         (irq)
    );

    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] q_exp[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One bus transaction; returns at the ack sample point.
    task automatic xfer(input string tag, input logic [31:0] addr, input logic [3:0] wstrb,
                        input logic [31:0] wdata, input logic [31:0] exp_rd);
        int          n;
        logic [31:0] e;
        if (iomem_ready) tick();
        q_exp.push_back(exp_rd);
        iomem_addr  = addr;
        iomem_wstrb = wstrb;
        iomem_wdata = wdata;
        iomem_valid = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!iomem_ready && n < 8);
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        e = q_exp.pop_front();
        check({tag, "_lat"}, 32'(n), 32'd1);
        check({tag, "_rdata"}, iomem_rdata, e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        reset       = 1'b1;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        iomem_addr  = '0;
        iomem_wdata = '0;
        pins_in     = '0;
        repeat (3) tick();
        check("rst_ready", 32'(iomem_ready), 32'd0);
        check("rst_rdata", iomem_rdata, 32'd0);
        check("rst_out", 32'(pins_out), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        reset = 1'b0;

        // OUT register with byte lanes
        xfer("out_wr_b0", 32'h0300_0000, 4'b0001, 32'h0000_A5C3, 32'h0);
        check("out_pins", 32'(pins_out), 32'h0000_00C3);
        tick();
        check("idle_ready", 32'(iomem_ready), 32'd0);
        check("idle_rdata", iomem_rdata, 32'd0);
        xfer("out_rd", 32'h0300_0000, 4'b0000, 32'h0, 32'h0000_00C3);
        xfer("out_wr_b01", 32'h0300_0000, 4'b0011, 32'h1234_5678, 32'h0000_00C3);
        xfer("out_wr_b23", 32'h0300_0000, 4'b1100, 32'hFFFF_FFFF, 32'h0000_5678);
        check("out_pins2", 32'(pins_out), 32'h0000_5678);

        // IRQ_EN keeps only N_IN bits
        xfer("irqen_wr", 32'h0300_000C, 4'b1111, 32'hFFFF_FFE4, 32'h0);
        xfer("irqen_rd", 32'h0300_000C, 4'b0000, 32'h0, 32'h0000_0004);
        xfer("in_rd0", 32'h0300_0004, 4'b0000, 32'h0, 32'h0);
        check("irq_idle", 32'(irq), 32'd0);

        // pin step: irq rises one cycle after IN/EDGE
        tick();
        pins_in[2] = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!irq && n < 40);
        check("in_latency", 32'(n), 32'(c_LAT + 1));

        // 3-cycle pulse on pin3, 1-cycle glitch on pin1
        pins_in[3] = 1'b1;
        repeat (3) tick();
        pins_in[3] = 1'b0;
        pins_in[1] = 1'b1;
        tick();
        pins_in[1] = 1'b0;
        repeat (12) tick();
        xfer("in_rd1", 32'h0300_0004, 4'b0000, 32'h0, 32'h0000_0004);
        xfer("edge_rd1", 32'h0300_0008, 4'b0000, 32'h0, c_DEB ? 32'h04 : 32'h0E);
        check("irq_set", 32'(irq), 32'd1);

        // W1C of EDGE[2]; irq drops one cycle later
        xfer("edge_w1c", 32'h0300_0008, 4'b0001, 32'h0000_0004, c_DEB ? 32'h04 : 32'h0E);
        check("irq_at_clr", 32'(irq), 32'd1);
        tick();
        check("irq_clr", 32'(irq), 32'd0);
        xfer("edge_rd2", 32'h0300_0008, 4'b0000, 32'h0, c_DEB ? 32'h00 : 32'h0A);
        xfer("edge_clrall", 32'h0300_0008, 4'b1111, 32'hFFFF_FFFF, c_DEB ? 32'h00 : 32'h0A);

        // falling edge must not set EDGE
        pins_in[2] = 1'b0;
        repeat (c_LAT + 3) tick();
        xfer("edge_fall", 32'h0300_0008, 4'b0000, 32'h0, 32'h0);
        xfer("in_rd2", 32'h0300_0004, 4'b0000, 32'h0, 32'h0);

        // set EDGE[0], drop pin0, then race a W1C against the next rise
        pins_in[0] = 1'b1;
        repeat (c_LAT + 3) tick();
        pins_in[0] = 1'b0;
        repeat (c_LAT + 3) tick();
        xfer("edge_pre", 32'h0300_0008, 4'b0000, 32'h0, 32'h0000_0001);
        tick();
        pins_in[0] = 1'b1;
        repeat (c_LAT - 1) tick();
        xfer("edge_race", 32'h0300_0008, 4'b0001, 32'h0000_0001, 32'h0000_0001);
        xfer("edge_race_rd", 32'h0300_0008, 4'b0000, 32'h0, 32'h0000_0001);

        // make irq high before the reset abort
        xfer("irqen_wr2", 32'h0300_000C, 4'b0001, 32'h0000_0005, 32'h0000_0004);
        repeat (2) tick();
        check("irq_pre_rst", 32'(irq), 32'd1);

        // reset during a pending write: no ack, no update
        pins_in     = '0;
        iomem_addr  = 32'h0300_0000;
        iomem_wstrb = 4'b1111;
        iomem_wdata = 32'h0000_FFFF;
        iomem_valid = 1'b1;
        reset       = 1'b1;
        tick();
        check("abort_ready", 32'(iomem_ready), 32'd0);
        check("abort_rdata", iomem_rdata, 32'd0);
        check("abort_out", 32'(pins_out), 32'd0);
        check("abort_irq", 32'(irq), 32'd0);
        reset       = 1'b0;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;

        xfer("post_rst_out", 32'h0300_0000, 4'b0000, 32'h0, 32'h0);
        xfer("post_rst_edge", 32'h0300_0008, 4'b0000, 32'h0, 32'h0);
        xfer("post_rst_irqen", 32'h0300_000C, 4'b0000, 32'h0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gpio_iomem.md
GPIO_IOMEM -- requirements
Module: gpio_iomem

Interface
REQ-001 The block SHALL have parameter N_IN, default 5, meaning the number of input pins (buttons), legal range 1..16.
REQ-002 The block SHALL have parameter N_OUT, default 16, meaning the width of the output register, legal range 1..32.
REQ-003 The block SHALL have parameter DEB_CYCLES, default 65000, meaning the number of consecutive stable cycles needed to accept an input change, legal range 2..2^20.
REQ-004 The block SHALL have these ports, in this order:
- clk  in  1  the single clock; every register in the block is clocked on its rising edge.
- reset  in  1  synchronous, active-high reset.
- iomem_valid  in  1  transaction request, already qualified by the 0x03xx_xxxx address decode.
- iomem_ready  out  1  one-cycle transaction acknowledge.
- iomem_wstrb  in  4  byte write strobes; all zero means a read.
- iomem_addr  in  32  byte address; only bits [3:2] are decoded.
- iomem_wdata  in  32  write data.
- iomem_rdata  out  32  read data, valid while iomem_ready is high.
- pins_in  in  N_IN  raw, asynchronous input pins.
- pins_out  out  N_OUT  contents of the OUT register.
- irq  out  1  level interrupt.

Function
REQ-005 The block SHALL decode the register map as follows:
- addr[3:2]=0: OUT, read/write, N_OUT bits.
- addr[3:2]=1: IN, read-only, debounced inputs.
- addr[3:2]=2: EDGE, sticky rising-edge flags, write-1-to-clear.
- addr[3:2]=3: IRQ_EN, read/write, N_IN bits.
REQ-006 The block SHALL zero-extend every register to 32 bits on reads; writes to unimplemented bits SHALL be ignored.
REQ-007 The handshake SHALL work as follows: when iomem_valid=1 and iomem_ready=0, iomem_ready SHALL be 1 on the next cycle for exactly one cycle, then return to 0. A held valid SHALL therefore get one ack every 2 cycles.
REQ-008 A write SHALL take effect on the same clock edge that raises iomem_ready, and SHALL apply only to byte lanes with iomem_wstrb[k]=1.
REQ-009 iomem_rdata SHALL hold the value of the addressed register at the time of the request and SHALL be 0 whenever iomem_ready=0.
REQ-010 Each pins_in bit SHALL pass through a 2-flop synchroniser before any other use.
REQ-011 Debounce (macro defined) SHALL work per bit as follows:
- A counter clears whenever the synchronised value equals the IN bit.
- The counter increments while the two differ.
- When the count reaches DEB_CYCLES-1, the IN bit SHALL take the synchronised value and the counter SHALL clear.
- A clean input step therefore appears in IN exactly 2+DEB_CYCLES cycles after the pin changes.
- A glitch shorter than DEB_CYCLES cycles SHALL never change IN.
REQ-012 An EDGE bit SHALL be set on the same clock edge on which its IN bit goes 0 to 1; falling edges SHALL not set it.
REQ-013 If a W1C write to an EDGE bit and a new rising edge on that bit occur on the same cycle, the set SHALL win and the bit SHALL remain 1.
REQ-014 irq SHALL be a registered value equal to the OR-reduction of (EDGE & IRQ_EN), so it lags its sources by one cycle.
REQ-015 An access with iomem_valid=1 to any address SHALL always be acknowledged, with no timeouts or error responses.

Reset
REQ-016 While reset=1 the block SHALL clear OUT, IN, EDGE, IRQ_EN, every debounce counter, the synchroniser flops, iomem_ready, iomem_rdata and irq to 0 on the next clk edge.
REQ-017 If reset asserts during a pending transaction, the transaction SHALL be aborted with no ack and no register update.
REQ-018 After reset deasserts, the first transaction SHALL be accepted on the first cycle in which iomem_valid=1.

Configuration
REQ-019 The single compile-time feature SHALL be the macro GPIO_IOMEM_DEBOUNCE_EN:
- Defined: the debounce counters of REQ-011 SHALL be built.
- Undefined: no counters SHALL be built, DEB_CYCLES SHALL be ignored, and IN SHALL equal the synchroniser output, so the pin-to-IN latency is 2 cycles.
- In both cases the register map and handshake SHALL be identical.

Verification (N_IN=5, N_OUT=16, DEB_CYCLES=4, macro defined unless noted)
REQ-020 A write of 0x0000_A5C3 to addr 0x0300_0000 with wstrb=4'b0001 SHALL produce pins_out=0x00C3, and a following read of addr 0x0 SHALL return 0x0000_00C3, each acked in exactly 1 cycle.
REQ-021 Holding pins_in[2] at 1 SHALL make IN read 0x04 from cycle 6 onward and set EDGE[2]; a 3-cycle pulse on pins_in[3] SHALL leave IN and EDGE bit 3 unchanged.
REQ-022 With IRQ_EN=0x04 and EDGE[2]=1, irq SHALL be 1; writing 0x04 to addr 0x8 SHALL clear EDGE[2], and irq SHALL be 0 one cycle later.
REQ-023 When a W1C of EDGE[0] lands on the same cycle as a rising edge on IN[0], EDGE SHALL read 0x01 afterwards.
REQ-024 Raising reset while iomem_valid=1 and ready is pending SHALL produce no ack, and all outputs SHALL be 0 after one edge.
REQ-025 With the macro undefined, a pin step SHALL appear in IN after 2 cycles, and a 1-cycle glitch SHALL appear in IN.
